// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: handshaked signed ALU sitting between issue and writeback.
//   ADD/SUB/AND/OR/XOR post one cycle after accept. MUL (shift-add) and
//   DIV (restoring) work on operand magnitudes, one bit per cycle for
//   WIDTH cycles, then apply signs at the final post.
// Build option: define ALU_DIV_EN to build the divider. Without it, opcode
//   110 is reported as an illegal op and div_by_zero is always 0.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   request handshake (a, b, alu_op, cin captured on accept)
//   out_valid        one-cycle pulse per posted result
//   result           2*WIDTH signed result (quotient for DIV), held
//   rem              WIDTH signed remainder (DIV only), held
//   cout             carry (ADD) / borrow (SUB)
//   div_by_zero      DIV with b==0
//   op_err           reserved or not-built opcode
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         alu_op,
  input  logic               cin,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   rem,
  output logic               cout,
  output logic               div_by_zero,
  output logic               op_err
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] DIV_BUSY = 2'd2;
  localparam logic [2:0] OP_DIV   = 3'b110;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Shared iterative datapath:
  //   MUL: acc = running product, sha = shifted multiplicand, shb = multiplier
  //   DIV: acc[WIDTH-1:0] = partial remainder, sha[WIDTH-1:0] = divisor,
  //        shb = dividend shifting out / quotient shifting in
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     sha_q, sha_d;
  logic [WIDTH-1:0]  shb_q, shb_d;
  logic              neg_q, neg_d;

  logic              vld_q;
  logic [W2-1:0]     res_q;
  logic [WIDTH-1:0]  rem_q;
  logic              cout_q, dbz_q, err_q;

  logic              post;
  logic [W2-1:0]     p_res;
  logic [WIDTH-1:0]  p_rem;
  logic              p_cout, p_dbz, p_err;

  logic              accept;
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Single-cycle arithmetic, exact at WIDTH+1 bits.
  logic [WIDTH:0]    add_s, sub_s, add_u, sub_rhs;
  logic              borrow;
  assign add_s   = {a[WIDTH-1], a} + {b[WIDTH-1], b} + {{WIDTH{1'b0}}, cin};
  assign sub_s   = {a[WIDTH-1], a} - {b[WIDTH-1], b} - {{WIDTH{1'b0}}, cin};
  assign add_u   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sub_rhs = {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign borrow  = {1'b0, a} < sub_rhs;

  logic [WIDTH-1:0]  land, lor, lxor;
  assign land = a & b;
  assign lor  = a | b;
  assign lxor = a ^ b;

  // Magnitudes are unsigned WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  logic [WIDTH-1:0]  mag_a, mag_b;
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  logic [W2-1:0]     mul_acc;
  assign mul_acc = acc_q + (shb_q[0] ? sha_q : '0);

`ifdef ALU_DIV_EN
  logic              rneg_q, rneg_d;
  logic [WIDTH:0]    part;
  logic              div_ge;
  logic [WIDTH-1:0]  nrem, qnext;
  logic [W2-1:0]     q_ext;
  assign part   = {acc_q[WIDTH-1:0], shb_q[WIDTH-1]};
  assign div_ge = part >= {1'b0, sha_q[WIDTH-1:0]};
  // When div_ge the difference is below the divisor, so WIDTH bits suffice.
  assign nrem   = div_ge ? (part[WIDTH-1:0] - sha_q[WIDTH-1:0]) : part[WIDTH-1:0];
  assign qnext  = {shb_q[WIDTH-2:0], div_ge};
  assign q_ext  = {{WIDTH{1'b0}}, qnext};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    neg_d   = neg_q;
`ifdef ALU_DIV_EN
    rneg_d  = rneg_q;
`endif
    post    = 1'b0;
    p_res   = '0;
    p_rem   = '0;
    p_cout  = 1'b0;
    p_dbz   = 1'b0;
    p_err   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        case (alu_op)
          OP_ADD: begin post = 1'b1; p_res = {{(WIDTH-1){add_s[WIDTH]}}, add_s}; p_cout = add_u[WIDTH]; end
          OP_SUB: begin post = 1'b1; p_res = {{(WIDTH-1){sub_s[WIDTH]}}, sub_s}; p_cout = borrow; end
          OP_AND: begin post = 1'b1; p_res = {{WIDTH{land[WIDTH-1]}}, land}; end
          OP_OR:  begin post = 1'b1; p_res = {{WIDTH{lor[WIDTH-1]}}, lor}; end
          OP_XOR: begin post = 1'b1; p_res = {{WIDTH{lxor[WIDTH-1]}}, lxor}; end
          OP_MUL: begin
            acc_d   = '0;
            sha_d   = {{WIDTH{1'b0}}, mag_a};
            shb_d   = mag_b;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d   = CW'(WIDTH - 1);
            state_d = MUL_BUSY;
          end
`ifdef ALU_DIV_EN
          OP_DIV: begin
            if (b == '0) begin
              post  = 1'b1;
              p_rem = a;
              p_dbz = 1'b1;
            end else begin
              acc_d   = '0;
              sha_d   = {{WIDTH{1'b0}}, mag_b};
              shb_d   = mag_a;
              neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
              rneg_d  = a[WIDTH-1];
              cnt_d   = CW'(WIDTH - 1);
              state_d = DIV_BUSY;
            end
          end
`endif
          default: begin post = 1'b1; p_err = 1'b1; end
        endcase
      end
      MUL_BUSY: begin
        acc_d = mul_acc;
        sha_d = sha_q << 1;
        shb_d = shb_q >> 1;
        // The last iteration posts directly from the combinational sum.
        if (cnt_q == '0) begin
          post    = 1'b1;
          p_res   = neg_q ? -mul_acc : mul_acc;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef ALU_DIV_EN
      DIV_BUSY: begin
        acc_d = {{WIDTH{1'b0}}, nrem};
        shb_d = qnext;
        if (cnt_q == '0) begin
          post    = 1'b1;
          p_res   = neg_q ? -q_ext : q_ext;
          p_rem   = rneg_q ? -nrem : nrem;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      neg_q   <= 1'b0;
`ifdef ALU_DIV_EN
      rneg_q  <= 1'b0;
`endif
      vld_q   <= 1'b0;
      res_q   <= '0;
      rem_q   <= '0;
      cout_q  <= 1'b0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      neg_q   <= neg_d;
`ifdef ALU_DIV_EN
      rneg_q  <= rneg_d;
`endif
      vld_q   <= post;
      if (post) begin
        res_q  <= p_res;
        rem_q  <= p_rem;
        cout_q <= p_cout;
        dbz_q  <= p_dbz;
        err_q  <= p_err;
      end
    end
  end

  assign out_valid   = vld_q;
  assign result      = res_q;
  assign rem         = rem_q;
  assign cout        = cout_q;
  assign div_by_zero = dbz_q;
  assign op_err      = err_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed bench for alu_nbit_seq at WIDTH=8. Output bundle compared as
// {out_valid, result[15:0], rem[7:0], cout, div_by_zero, op_err}.
module tb_alu_nbit_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic [2:0]     alu_op;
  logic           cin;
  logic           out_valid;
  logic [2*W-1:0] result;
  logic [W-1:0]   rem;
  logic           cout, div_by_zero, op_err;

  int checks   = 0;
  int failures = 0;
  logic [27:0] exp_v;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .cin(cin),
    .out_valid(out_valid), .result(result), .rem(rem), .cout(cout),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] outs();
    return {out_valid, result, rem, cout, div_by_zero, op_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb2,
                       input logic [2:0] op, input logic c);
    in_valid = 1'b1; a = ta; b = tb2; alu_op = op; cin = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = '0; cin = 1'b0;
    tick(); tick();
    checks++;
    if (outs() !== 28'h0) begin failures++; $display("FAIL reset_outs got %h exp %h", outs(), 28'h0); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got %b exp 0", in_ready); end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_high got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vr [4];
    logic        vc [4];
    va = '{8'h88, 8'hFF, 8'h7F, 8'h80};
    vb = '{8'h05, 8'h01, 8'h7F, 8'h80};
    vr = '{16'hFF8D, 16'h0000, 16'h00FF, 16'hFF00};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'b000, (i == 2) ? 1'b1 : 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL add_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      exp_v = {1'b1, vr[i], 8'h00, vc[i], 1'b0, 1'b0};
      checks++;
      if (outs() !== exp_v) begin failures++; $display("FAIL add[%0d] got %h exp %h", i, outs(), exp_v); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, result} !== {1'b0, 16'hFF00}) begin
      failures++; $display("FAIL add_hold got %b/%h exp 0/ff00", out_valid, result);
    end
  endtask

  task automatic test_sub();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic        vi [4];
    logic [15:0] vr [4];
    logic        vc [4];
    va = '{8'h6E, 8'h0B, 8'h05, 8'h05};
    vb = '{8'hF8, 8'hEC, 8'h05, 8'h03};
    vi = '{1'b0, 1'b0, 1'b1, 1'b1};
    vr = '{16'h0076, 16'h001F, 16'hFFFF, 16'h0001};
    vc = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'b001, vi[i]);
      tick();
      exp_v = {1'b1, vr[i], 8'h00, vc[i], 1'b0, 1'b0};
      checks++;
      if (outs() !== exp_v) begin failures++; $display("FAIL sub[%0d] got %h exp %h", i, outs(), exp_v); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_logic();
    logic [2:0]  vo [3];
    logic [15:0] vr [3];
    vo = '{3'b010, 3'b011, 3'b100};
    vr = '{16'h0003, 16'hFFCF, 16'hFFCC};
    for (int i = 0; i < 3; i++) begin
      drive(8'hC3, 8'h0F, vo[i], 1'b1);
      tick();
      exp_v = {1'b1, vr[i], 8'h00, 1'b0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp_v) begin failures++; $display("FAIL logic[%0d] got %h exp %h", i, outs(), exp_v); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  // Each new MUL is driven in the post cycle of the previous one.
  task automatic test_mul();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vr [4];
    va = '{8'd50, 8'hFC, 8'h80, 8'h80};
    vb = '{8'd40, 8'h03, 8'h80, 8'h7F};
    vr = '{16'h07D0, 16'hFFF4, 16'h4000, 16'hC080};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'b101, 1'b1);
      tick();
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        failures++; $display("FAIL mul[%0d]_accept ready/valid got %b exp 00", i, {in_ready, out_valid});
      end
      drive(8'h01, 8'h01, 3'b000, 1'b0);  // must be ignored while busy
      for (int k = 1; k < W; k++) begin
        tick();
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
          failures++; $display("FAIL mul[%0d]_busy%0d ready/valid got %b exp 00", i, k, {in_ready, out_valid});
        end
      end
      tick();
      exp_v = {1'b1, vr[i], 8'h00, 1'b0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp_v) begin failures++; $display("FAIL mul[%0d] got %h exp %h", i, outs(), exp_v); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL mul[%0d]_post_ready got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, result} !== {1'b0, 16'hC080}) begin
      failures++; $display("FAIL mul_single_pulse got %b/%h exp 0/c080", out_valid, result);
    end
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vq [4];
    logic [7:0]  vr [4];
    va = '{8'hF7, 8'h0F, 8'h80, 8'h07};
    vb = '{8'h02, 8'hFC, 8'hFF, 8'h80};
    vq = '{16'hFFFC, 16'hFFFD, 16'h0080, 16'h0000};
    vr = '{8'hFF, 8'h03, 8'h00, 8'h07};
    drive(8'hF7, 8'h00, 3'b110, 1'b0);
    tick();
    exp_v = {1'b1, 16'h0000, 8'hF7, 1'b0, 1'b1, 1'b0};
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL div_by_zero got %h exp %h", outs(), exp_v); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL div_by_zero_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'b110, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < W; k++) begin
        tick();
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
          failures++; $display("FAIL div[%0d]_busy%0d ready/valid got %b exp 00", i, k, {in_ready, out_valid});
        end
      end
      tick();
      exp_v = {1'b1, vq[i], vr[i], 1'b0, 1'b0, 1'b0};
      checks++;
      if (outs() !== exp_v) begin failures++; $display("FAIL div[%0d] got %h exp %h", i, outs(), exp_v); end
    end
    tick();
  endtask
`endif

  task automatic test_op_err();
    drive(8'hF7, 8'h02, 3'b111, 1'b1);
    tick();
    exp_v = {1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1};
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL op_111 got %h exp %h", outs(), exp_v); end
`ifndef ALU_DIV_EN
    drive(8'hF7, 8'h02, 3'b110, 1'b0);
    tick();
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL op_110_nodiv got %h exp %h", outs(), exp_v); end
`endif
    drive(8'h01, 8'h02, 3'b000, 1'b0);
    tick();
    exp_v = {1'b1, 16'h0003, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL op_err_clear got %h exp %h", outs(), exp_v); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    drive(8'd50, 8'd40, 3'b101, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (outs() !== 28'h0) begin failures++; $display("FAIL rst_mid_outs got %h exp %h", outs(), 28'h0); end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %b exp 1", in_ready); end
    stray = 0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL rst_mid_no_post got %0d pulses exp 0", stray); end
    drive(8'd2, 8'd3, 3'b000, 1'b0);
    tick();
    exp_v = {1'b1, 16'h0005, 8'h00, 1'b0, 1'b0, 1'b0};
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL rst_mid_add got %h exp %h", outs(), exp_v); end
    // Reset and accept on the same edge: reset wins, request dropped.
    rst = 1'b1;
    drive(8'd7, 8'd1, 3'b000, 1'b0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (outs() !== 28'h0) begin failures++; $display("FAIL rst_priority got %h exp %h", outs(), 28'h0); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
`ifdef ALU_DIV_EN
    test_div();
`endif
    test_op_err();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
